// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flags FIFO and its benches.
package sync_fifo_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flags: one synchronous write port, and a read
// port that is registered (standard mode) or asynchronous (FWFT mode).
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = MODE_STD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          re,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_async_read
      assign rdata = mem[raddr];
      // Read strobe and reset are not needed by the asynchronous port.
      logic unused_ctl;
      assign unused_ctl = &{1'b0, rst, re};
    end else begin : g_reg_read
      // Registered read; a same-address write in this cycle yields the old word.
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow and an optional high-water mark.
// Define SYNC_FIFO_HWM_EN to enable the max_count high-water mark register;
// otherwise max_count is tied to zero.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FWFT          = MODE_STD,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [cnt_width(DEPTH)-1:0]   max_count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_THRESH);

  generate
    if (DATA_WIDTH < 1) begin : g_bad_width
      $fatal(1, "sync_fifo_flags: DATA_WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 2");
    end
    if (FWFT > MODE_FWFT) begin : g_bad_mode
      $fatal(1, "sync_fifo_flags: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_af
      $fatal(1, "sync_fifo_flags: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 1 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "sync_fifo_flags: AEMPTY_THRESH out of range");
    end
  endgenerate

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count_next;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status flags decode the registered count only.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Accept rules on pre-edge state; a full FIFO still takes a write if a pop frees a slot.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // Next occupancy: unchanged when both or neither transfer is accepted.
  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + CW'(1);
    else if (rd_acc && !wr_acc) count_next = count - CW'(1);
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
      count <= count_next;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && empty)   underflow <= 1'b1;
      else if (clr_err)     underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_HWM_EN
  // High-water mark tracks count_next so it moves on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst)                         max_count <= '0;
    else if (clr_err)                max_count <= count_next;
    else if (count_next > max_count) max_count <= count_next;
  end
`else
  assign max_count = '0;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_dout_fwft
      // Present the head word only while data exists; zero when empty.
      assign dout = empty ? '0 : mem_rdata;
    end else begin : g_dout_std
      assign dout = mem_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and an FWFT instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ov_s, un_s;
  logic       full_f, empty_f, af_f, ae_f, ov_f, un_f;
  logic [4:0] count_s, max_s, count_f, max_f;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_WIDTH (8), .DEPTH (DEPTH), .FWFT (0),
    .AFULL_THRESH (AF), .AEMPTY_THRESH (AE)
  ) u_std (
    .clk (clk), .rst (rst), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .clr_err (clr_err), .dout (dout_s), .full (full_s), .empty (empty_s),
    .almost_full (af_s), .almost_empty (ae_s), .count (count_s),
    .overflow (ov_s), .underflow (un_s), .max_count (max_s)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (8), .DEPTH (DEPTH), .FWFT (1),
    .AFULL_THRESH (AF), .AEMPTY_THRESH (AE)
  ) u_fwft (
    .clk (clk), .rst (rst), .wr_en (wr_en), .din (din), .rd_en (rd_en),
    .clr_err (clr_err), .dout (dout_f), .full (full_f), .empty (empty_f),
    .almost_full (af_f), .almost_empty (ae_f), .count (count_f),
    .overflow (ov_f), .underflow (un_f), .max_count (max_f)
  );

  logic [47:0] obs;
  assign obs = {count_s, full_s, empty_s, af_s, ae_s, ov_s, un_s, max_s,
                count_f, full_f, empty_f, af_f, ae_f, ov_f, un_f, max_f,
                dout_s, dout_f};

  // Reference model
  logic [7:0] q[$];
  logic [7:0] m_dout_s;
  logic       m_ov, m_un;
  logic [4:0] m_max;

  int total = 0;
  int bad   = 0;

  function automatic logic [47:0] exp_all();
    int n;
    logic [15:0] stat;
    logic [7:0]  head;
    n = q.size();
    stat = {5'(n), n == int'(DEPTH), n == 0, n >= int'(AF), n <= int'(AE),
            m_ov, m_un, m_max};
    head = (n != 0) ? q[0] : 8'h00;
    return {stat, stat, m_dout_s, head};
  endfunction

  // Apply one clock of stimulus and advance the model with pre-edge state.
  task automatic drive(input logic r, input logic w, input logic [7:0] d,
                       input logic rd, input logic c);
    int n;
    bit rd_ok, wr_ok;
    rst = r; wr_en = w; din = d; rd_en = rd; clr_err = c;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout_s = 8'h00; m_ov = 1'b0; m_un = 1'b0; m_max = 5'd0;
    end else begin
      n = q.size();
      rd_ok = rd && (n > 0);
      wr_ok = w && ((n < int'(DEPTH)) || rd_ok);
      if (rd_ok) m_dout_s = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ov = 1'b1; else if (c) m_ov = 1'b0;
      if (rd && n == 0) m_un = 1'b1; else if (c) m_un = 1'b0;
`ifdef SYNC_FIFO_HWM_EN
      if (c) m_max = 5'(q.size());
      else if (q.size() > int'(m_max)) m_max = 5'(q.size());
`endif
    end
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0, 0);
    drive(1, 1, 8'h55, 1, 1);
    total++;
    if (obs !== exp_all()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_all());
    end
    total++;
    if ({count_s, full_s, empty_s, af_s, ae_s, ov_s, un_s, max_s, dout_s, dout_f}
        !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      bad++; $display("FAIL reset_values got=%h/%b%b%b%b%b%b/%h/%h/%h",
                      count_s, full_s, empty_s, af_s, ae_s, ov_s, un_s, max_s, dout_s, dout_f);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'(i + 1), 0, 0);
      total++;
      if (obs !== exp_all()) begin
        bad++; $display("FAIL fill i=%0d got=%h exp=%h", i, obs, exp_all());
      end
      if (i == 12 || i == 13) begin
        total++;
        if (af_s !== (i == 13)) begin
          bad++; $display("FAIL afull_edge count=%0d got=%b exp=%b", i + 1, af_s, i == 13);
        end
      end
    end
    total++;
    if ({full_s, count_s} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL full_after_16 got full=%b count=%0d exp full=1 count=16", full_s, count_s);
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      total++;
      if (obs !== exp_all() || dout_s !== 8'(i + 1)) begin
        bad++; $display("FAIL drain i=%0d got=%h exp=%h dout=%h want=%h",
                        i, obs, exp_all(), dout_s, 8'(i + 1));
      end
    end
    total++;
    if (empty_s !== 1'b1) begin
      bad++; $display("FAIL empty_after_drain got=%b exp=1", empty_s);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) drive(0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'($urandom), 1, 0);
      total++;
      if (obs !== exp_all() || count_s !== 5'd16 || ov_s !== 1'b0) begin
        bad++; $display("FAIL full_rw i=%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      total++;
      if (obs !== exp_all()) begin
        bad++; $display("FAIL full_rw_drain i=%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
  endtask

  task automatic test_empty_rw();
    drive(0, 1, 8'hA5, 1, 0);
    total++;
    if (obs !== exp_all() || un_s !== 1'b1 || count_s !== 5'd1) begin
      bad++; $display("FAIL empty_rw got=%h exp=%h", obs, exp_all());
    end
    drive(0, 0, 8'h00, 1, 0);
    total++;
    if (dout_s !== 8'hA5 || obs !== exp_all()) begin
      bad++; $display("FAIL empty_rw_read got=%h exp=a5", dout_s);
    end
    drive(0, 0, 8'h00, 0, 1);
    total++;
    if (obs !== exp_all() || un_s !== 1'b0) begin
      bad++; $display("FAIL underflow_clear got=%h exp=%h", obs, exp_all());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) drive(0, 1, 8'(8'h40 + i), 0, 0);
    drive(0, 1, 8'hEE, 0, 0);
    total++;
    if (obs !== exp_all() || ov_s !== 1'b1 || count_s !== 5'd16) begin
      bad++; $display("FAIL overflow_set got=%h exp=%h", obs, exp_all());
    end
    drive(0, 0, 8'h00, 0, 1);
    total++;
    if (obs !== exp_all() || ov_s !== 1'b0) begin
      bad++; $display("FAIL overflow_clear got=%h exp=%h", obs, exp_all());
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      total++;
      if (obs !== exp_all() || dout_s !== 8'(8'h40 + i)) begin
        bad++; $display("FAIL overflow_intact i=%0d got=%h want=%h", i, dout_s, 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_fwft();
    drive(0, 1, 8'h3C, 0, 0);
    total++;
    if (empty_f !== 1'b0 || dout_f !== 8'h3C || obs !== exp_all()) begin
      bad++; $display("FAIL fwft_show got empty=%b dout=%h exp empty=0 dout=3c", empty_f, dout_f);
    end
    drive(0, 0, 8'h00, 1, 0);
    total++;
    if (empty_f !== 1'b1 || dout_f !== 8'h00 || obs !== exp_all()) begin
      bad++; $display("FAIL fwft_pop got empty=%b dout=%h exp empty=1 dout=00", empty_f, dout_f);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] want_max;
    drive(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h10 + i), 0, 0);
`ifdef SYNC_FIFO_HWM_EN
    want_max = 5'd5;
`else
    want_max = 5'd0;
`endif
    total++;
    if (max_s !== want_max || count_s !== 5'd5 || obs !== exp_all()) begin
      bad++; $display("FAIL hwm_before_reset got max=%0d count=%0d exp max=%0d count=5",
                      max_s, count_s, want_max);
    end
    drive(1, 0, 8'h00, 0, 0);
    total++;
    if ({count_s, empty_s, dout_s, max_s} !== {5'd0, 1'b1, 8'h00, 5'd0} || obs !== exp_all()) begin
      bad++; $display("FAIL reset_mid got count=%0d empty=%b dout=%h max=%0d",
                      count_s, empty_s, dout_s, max_s);
    end
    drive(0, 1, 8'h77, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    total++;
    if (dout_s !== 8'h77 || obs !== exp_all()) begin
      bad++; $display("FAIL post_reset_read got=%h exp=77", dout_s);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int wp;
      logic r, w, rd, c;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      c  = ($urandom_range(0, 99) < 4);
      r  = ($urandom_range(0, 299) == 0);
      drive(r, w, 8'($urandom), rd, c);
      total++;
      if (obs !== exp_all()) begin
        bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_all());
      end
    end
  endtask

  initial begin
    m_dout_s = 8'h00; m_ov = 1'b0; m_un = 1'b0; m_max = 5'd0;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_overflow();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
